// File: rtl/axi_sram_pkg.sv
// rtl/axi_sram_pkg.sv - shared types, response codes and burst helpers for the AXI SRAM responder
package axi_sram_pkg;

   typedef enum logic [1:0] {
      FIXED    = 2'd0,
      INCR     = 2'd1,
      WRAP     = 2'd2,
      RESERVED = 2'd3
   } burst_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_WRESP = 2'd3
   } state_e;

   typedef enum logic {
      PRIO_RD = 1'b0,
      PRIO_WR = 1'b1
   } prio_e;

   function automatic logic wrap_len_ok(input logic [7:0] len);
      return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
   endfunction

endpackage

// File: rtl/axi_sram_burst_addr.sv
// rtl/axi_sram_burst_addr.sv - next beat address for FIXED/INCR bursts, WRAP under AXI_SRAM_WRAP_BURST_EN
module axi_sram_burst_addr
   import axi_sram_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
) (
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [7:0]            len_i,
   input  logic [2:0]            size_i,
   input  logic [1:0]            burst_i,
   output logic [ADDR_WIDTH-1:0] next_addr_o
);

   logic [ADDR_WIDTH-1:0] step;
   logic [ADDR_WIDTH-1:0] incr_addr;

   assign step      = ADDR_WIDTH'(1) << size_i;
   assign incr_addr = addr_i + step;

`ifdef AXI_SRAM_WRAP_BURST_EN
   // Wrap window is (len+1) beats; len is restricted to 2^n-1 so the window is a power of two.
   logic [ADDR_WIDTH-1:0] wrap_mask;
   assign wrap_mask = ((ADDR_WIDTH'(len_i) + ADDR_WIDTH'(1)) << size_i) - ADDR_WIDTH'(1);
`else
   logic unused_len;
   assign unused_len = ^len_i;
`endif

   always_comb begin
      next_addr_o = incr_addr;
      case (burst_i)
         FIXED:   next_addr_o = addr_i;
`ifdef AXI_SRAM_WRAP_BURST_EN
         WRAP:    next_addr_o = (addr_i & ~wrap_mask) | (incr_addr & wrap_mask);
`endif
         default: next_addr_o = incr_addr;
      endcase
   end

endmodule

// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - single-transaction AXI4 responder over a byte-enable word SRAM
// AXI_SRAM_WRAP_BURST_EN enables WRAP bursts; otherwise WRAP is answered with SLVERR.
module axi_sram_slave
   import axi_sram_pkg::*;
#(
   parameter int DEPTH_WORDS = 4096,
   parameter int ID_WIDTH    = 4,
   parameter int ADDR_WIDTH  = 32
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic [ID_WIDTH-1:0]   s_aw_id_i,
   input  logic [ADDR_WIDTH-1:0] s_aw_addr_i,
   input  logic [7:0]            s_aw_len_i,
   input  logic [2:0]            s_aw_size_i,
   input  logic [1:0]            s_aw_burst_i,
   input  logic                  s_aw_lock_i,
   input  logic [3:0]            s_aw_cache_i,
   input  logic [2:0]            s_aw_prot_i,
   input  logic [3:0]            s_aw_qos_i,
   input  logic [3:0]            s_aw_region_i,
   input  logic                  s_aw_user_i,
   input  logic                  s_aw_valid_i,
   output logic                  s_aw_ready_o,
   input  logic [31:0]           s_w_data_i,
   input  logic [3:0]            s_w_strb_i,
   input  logic                  s_w_last_i,
   input  logic                  s_w_user_i,
   input  logic                  s_w_valid_i,
   output logic                  s_w_ready_o,
   output logic [ID_WIDTH-1:0]   s_b_id_o,
   output logic [1:0]            s_b_resp_o,
   output logic                  s_b_valid_o,
   input  logic                  s_b_ready_i,
   input  logic [ID_WIDTH-1:0]   s_ar_id_i,
   input  logic [ADDR_WIDTH-1:0] s_ar_addr_i,
   input  logic [7:0]            s_ar_len_i,
   input  logic [2:0]            s_ar_size_i,
   input  logic [1:0]            s_ar_burst_i,
   input  logic                  s_ar_lock_i,
   input  logic [3:0]            s_ar_cache_i,
   input  logic [2:0]            s_ar_prot_i,
   input  logic [3:0]            s_ar_qos_i,
   input  logic [3:0]            s_ar_region_i,
   input  logic                  s_ar_user_i,
   input  logic                  s_ar_valid_i,
   output logic                  s_ar_ready_o,
   output logic [ID_WIDTH-1:0]   s_r_id_o,
   output logic [31:0]           s_r_data_o,
   output logic [1:0]            s_r_resp_o,
   output logic                  s_r_last_o,
   output logic                  s_r_valid_o,
   input  logic                  s_r_ready_i
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   state_e                state_q;
   prio_e                 prio_q;
   logic [ID_WIDTH-1:0]   id_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [7:0]            len_q;
   logic [2:0]            size_q;
   logic [1:0]            burst_q;
   logic                  err_q;
   logic                  bad_last_q;
   logic [7:0]            beat_q;
   logic                  r_last_q;
   logic [31:0]           rdata_q;
   logic [31:0]           mem_q [DEPTH_WORDS];

   logic                  ar_hs;
   logic                  aw_hs;
   logic                  w_hs;
   logic                  rd_next;
   logic                  rd_en;
   logic [IDX_W-1:0]      rd_idx;
   logic [ADDR_WIDTH-1:0] next_addr;
   logic [7:0]            g_len;
   logic [2:0]            g_size;
   logic [1:0]            g_burst;
   logic                  wrap_bad;
   logic                  err_new;
   logic                  unused_sideband;

   assign unused_sideband = ^{s_aw_lock_i, s_aw_cache_i, s_aw_prot_i, s_aw_qos_i, s_aw_region_i,
                              s_aw_user_i, s_ar_lock_i, s_ar_cache_i, s_ar_prot_i, s_ar_qos_i,
                              s_ar_region_i, s_ar_user_i, s_w_user_i};

   // Only one ready can rise when both valids are pending; prio picks the winner.
   assign s_ar_ready_o = aresetn && (state_q == S_IDLE) && (!s_aw_valid_i || prio_q == PRIO_RD);
   assign s_aw_ready_o = aresetn && (state_q == S_IDLE) && (!s_ar_valid_i || prio_q == PRIO_WR);

   assign ar_hs   = s_ar_valid_i && s_ar_ready_o;
   assign aw_hs   = s_aw_valid_i && s_aw_ready_o;
   assign w_hs    = (state_q == S_WRITE) && s_w_valid_i;
   assign rd_next = (state_q == S_READ) && s_r_ready_i && !r_last_q;
   assign rd_en   = ar_hs || rd_next;
   assign rd_idx  = ar_hs ? s_ar_addr_i[2 +: IDX_W] : next_addr[2 +: IDX_W];

   assign s_w_ready_o = (state_q == S_WRITE);
   assign s_r_valid_o = (state_q == S_READ);
   assign s_b_valid_o = (state_q == S_WRESP);
   assign s_r_id_o    = id_q;
   assign s_b_id_o    = id_q;
   assign s_r_last_o  = r_last_q;
   assign s_r_resp_o  = err_q ? RESP_SLVERR : RESP_OKAY;
   assign s_r_data_o  = err_q ? 32'h0 : rdata_q;
   assign s_b_resp_o  = (err_q || bad_last_q) ? RESP_SLVERR : RESP_OKAY;

   axi_sram_burst_addr #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_burst_addr (
      .addr_i      (addr_q),
      .len_i       (len_q),
      .size_i      (size_q),
      .burst_i     (burst_q),
      .next_addr_o (next_addr)
   );

   always_comb begin
      g_len   = ar_hs ? s_ar_len_i   : s_aw_len_i;
      g_size  = ar_hs ? s_ar_size_i  : s_aw_size_i;
      g_burst = ar_hs ? s_ar_burst_i : s_aw_burst_i;
`ifdef AXI_SRAM_WRAP_BURST_EN
      wrap_bad = !wrap_len_ok(g_len);
`else
      wrap_bad = 1'b1;
`endif
      err_new = (g_size > 3'd2) || (g_burst == RESERVED) || ((g_burst == WRAP) && wrap_bad);
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q    <= S_IDLE;
         prio_q     <= PRIO_RD;
         id_q       <= '0;
         addr_q     <= '0;
         len_q      <= '0;
         size_q     <= '0;
         burst_q    <= '0;
         err_q      <= 1'b0;
         bad_last_q <= 1'b0;
         beat_q     <= '0;
         r_last_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (ar_hs || aw_hs) begin
                  id_q       <= ar_hs ? s_ar_id_i : s_aw_id_i;
                  addr_q     <= ar_hs ? s_ar_addr_i : s_aw_addr_i;
                  len_q      <= g_len;
                  size_q     <= g_size;
                  burst_q    <= g_burst;
                  err_q      <= err_new;
                  bad_last_q <= 1'b0;
                  beat_q     <= '0;
               end
               if (ar_hs) begin
                  state_q  <= S_READ;
                  prio_q   <= PRIO_WR;
                  r_last_q <= (s_ar_len_i == 8'd0);
               end else if (aw_hs) begin
                  state_q <= S_WRITE;
                  prio_q  <= PRIO_RD;
               end
            end
            S_READ: begin
               if (s_r_ready_i) begin
                  if (r_last_q) begin
                     state_q  <= S_IDLE;
                     r_last_q <= 1'b0;
                  end else begin
                     addr_q   <= next_addr;
                     beat_q   <= beat_q + 8'd1;
                     r_last_q <= ((beat_q + 8'd1) == len_q);
                  end
               end
            end
            S_WRITE: begin
               if (s_w_valid_i) begin
                  addr_q <= next_addr;
                  beat_q <= beat_q + 8'd1;
                  if (s_w_last_i) begin
                     state_q    <= S_WRESP;
                     bad_last_q <= (beat_q != len_q);
                  end
               end
            end
            S_WRESP: begin
               if (s_b_ready_i) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // SRAM array and output register are deliberately outside reset: contents survive aresetn.
   always_ff @(posedge aclk) begin
      if (w_hs && !err_q) begin
         for (int b = 0; b < 4; b++) begin
            if (s_w_strb_i[b]) mem_q[addr_q[2 +: IDX_W]][8*b +: 8] <= s_w_data_i[8*b +: 8];
         end
      end
      if (rd_en) rdata_q <= mem_q[rd_idx];
   end

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb/tb_axi_sram_slave.sv - directed bench for axi_sram_slave (single, burst, backpressure, arbitration, wrap, errors)
module tb_axi_sram_slave;

   localparam logic [1:0] B_FIXED = 2'd0;
   localparam logic [1:0] B_INCR  = 2'd1;
   localparam logic [1:0] B_WRAP  = 2'd2;
   localparam logic [1:0] B_RSVD  = 2'd3;
   localparam logic [1:0] OKAY    = 2'b00;
   localparam logic [1:0] SLVERR  = 2'b10;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic [3:0]  aw_id = '0, ar_id = '0;
   logic [31:0] aw_addr = '0, ar_addr = '0;
   logic [7:0]  aw_len = '0, ar_len = '0;
   logic [2:0]  aw_size = 3'd2, ar_size = 3'd2;
   logic [1:0]  aw_burst = 2'd1, ar_burst = 2'd1;
   logic        aw_valid = 1'b0, ar_valid = 1'b0;
   logic        aw_ready, ar_ready;
   logic [31:0] w_data = '0;
   logic [3:0]  w_strb = '0;
   logic        w_last = 1'b0, w_valid = 1'b0, w_ready;
   logic [3:0]  b_id;
   logic [1:0]  b_resp;
   logic        b_valid, b_ready = 1'b0;
   logic [3:0]  r_id;
   logic [31:0] r_data;
   logic [1:0]  r_resp;
   logic        r_last, r_valid, r_ready = 1'b0;
   logic        tie0 = 1'b0;
   logic [3:0]  tie4 = '0;
   logic [2:0]  tie3 = '0;

   int checks = 0;
   int errors = 0;

   logic [31:0] wd [16];
   logic [3:0]  ws [16];
   logic [31:0] rd_data [16];
   logic [1:0]  rd_resp [16];
   logic        rd_last [16];
   logic [3:0]  rd_id [16];
   int          rd_n;
   logic [1:0]  b_resp_got;
   logic [3:0]  b_id_got;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic [3:0]  id;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp_data;
      logic [1:0]  exp_resp;
   } vec_t;

   localparam int NV = 11;
   vec_t vecs [NV];

   always #5 aclk = ~aclk;

   axi_sram_slave #(.DEPTH_WORDS(4096), .ID_WIDTH(4), .ADDR_WIDTH(32)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_aw_id_i(aw_id), .s_aw_addr_i(aw_addr), .s_aw_len_i(aw_len), .s_aw_size_i(aw_size),
      .s_aw_burst_i(aw_burst), .s_aw_lock_i(tie0), .s_aw_cache_i(tie4), .s_aw_prot_i(tie3),
      .s_aw_qos_i(tie4), .s_aw_region_i(tie4), .s_aw_user_i(tie0), .s_aw_valid_i(aw_valid),
      .s_aw_ready_o(aw_ready),
      .s_w_data_i(w_data), .s_w_strb_i(w_strb), .s_w_last_i(w_last), .s_w_user_i(tie0),
      .s_w_valid_i(w_valid), .s_w_ready_o(w_ready),
      .s_b_id_o(b_id), .s_b_resp_o(b_resp), .s_b_valid_o(b_valid), .s_b_ready_i(b_ready),
      .s_ar_id_i(ar_id), .s_ar_addr_i(ar_addr), .s_ar_len_i(ar_len), .s_ar_size_i(ar_size),
      .s_ar_burst_i(ar_burst), .s_ar_lock_i(tie0), .s_ar_cache_i(tie4), .s_ar_prot_i(tie3),
      .s_ar_qos_i(tie4), .s_ar_region_i(tie4), .s_ar_user_i(tie0), .s_ar_valid_i(ar_valid),
      .s_ar_ready_o(ar_ready),
      .s_r_id_o(r_id), .s_r_data_o(r_data), .s_r_resp_o(r_resp), .s_r_last_o(r_last),
      .s_r_valid_o(r_valid), .s_r_ready_i(r_ready)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic timeout(input string nm);
      checks++;
      errors++;
      $display("FAIL %s: got no handshake expected handshake within bound", nm);
   endtask

   task automatic do_aw(input logic [31:0] a, input logic [7:0] l, input logic [2:0] sz,
                        input logic [1:0] bu, input logic [3:0] id);
      int n;
      logic rdy;
      aw_addr = a; aw_len = l; aw_size = sz; aw_burst = bu; aw_id = id; aw_valid = 1'b1;
      n = 0;
      do begin
         #1 rdy = aw_ready;
         @(posedge aclk); #1;
         n++;
      end while (!rdy && n < 50);
      aw_valid = 1'b0;
      if (!rdy) timeout("aw_handshake");
   endtask

   task automatic do_ar(input logic [31:0] a, input logic [7:0] l, input logic [2:0] sz,
                        input logic [1:0] bu, input logic [3:0] id);
      int n;
      logic rdy;
      ar_addr = a; ar_len = l; ar_size = sz; ar_burst = bu; ar_id = id; ar_valid = 1'b1;
      n = 0;
      do begin
         #1 rdy = ar_ready;
         @(posedge aclk); #1;
         n++;
      end while (!rdy && n < 50);
      ar_valid = 1'b0;
      if (!rdy) timeout("ar_handshake");
   endtask

   task automatic do_w(input logic [31:0] d, input logic [3:0] s, input logic l);
      int n;
      logic rdy;
      w_data = d; w_strb = s; w_last = l; w_valid = 1'b1;
      n = 0;
      do begin
         #1 rdy = w_ready;
         @(posedge aclk); #1;
         n++;
      end while (!rdy && n < 50);
      w_valid = 1'b0;
      w_last = 1'b0;
      if (!rdy) timeout("w_handshake");
   endtask

   task automatic do_b();
      int n;
      logic got;
      b_ready = 1'b1;
      n = 0;
      do begin
         #1 got = b_valid;
         if (got) begin
            b_resp_got = b_resp;
            b_id_got = b_id;
         end
         @(posedge aclk); #1;
         n++;
      end while (!got && n < 50);
      b_ready = 1'b0;
      if (!got) timeout("b_handshake");
   endtask

   task automatic wr_burst(input logic [31:0] a, input logic [7:0] l, input logic [2:0] sz,
                           input logic [1:0] bu, input logic [3:0] id, input int last_at);
      do_aw(a, l, sz, bu, id);
      for (int i = 0; i <= last_at; i++) do_w(wd[i], ws[i], i == last_at);
      do_b();
   endtask

   task automatic collect_r(input int max_beats);
      int n;
      logic got, done;
      rd_n = 0;
      r_ready = 1'b1;
      n = 0;
      done = 1'b0;
      while (!done && rd_n < max_beats && n < 100) begin
         #1 got = r_valid;
         if (got) begin
            rd_data[rd_n] = r_data;
            rd_resp[rd_n] = r_resp;
            rd_last[rd_n] = r_last;
            rd_id[rd_n]   = r_id;
         end
         @(posedge aclk); #1;
         n++;
         if (got) begin
            done = rd_last[rd_n];
            rd_n++;
         end
      end
      r_ready = 1'b0;
      if (n >= 100) timeout("r_beats");
   endtask

   initial begin
      int k, n, stall;

      vecs[0]  = '{1'b1, 32'h20,   3'd2, B_INCR,  4'd1,  32'h11223344, 4'hF, 32'h0,        OKAY};
      vecs[1]  = '{1'b1, 32'h20,   3'd2, B_INCR,  4'd2,  32'hAABBCCDD, 4'h5, 32'h0,        OKAY};
      vecs[2]  = '{1'b0, 32'h20,   3'd2, B_INCR,  4'd7,  32'h0,        4'h0, 32'h11BB33DD, OKAY};
      vecs[3]  = '{1'b1, 32'h24,   3'd2, B_INCR,  4'd4,  32'hCAFEF00D, 4'hF, 32'h0,        OKAY};
      vecs[4]  = '{1'b0, 32'h4024, 3'd2, B_INCR,  4'd8,  32'h0,        4'h0, 32'hCAFEF00D, OKAY};
      vecs[5]  = '{1'b1, 32'h24,   3'd3, B_INCR,  4'd9,  32'h12345678, 4'hF, 32'h0,        SLVERR};
      vecs[6]  = '{1'b0, 32'h24,   3'd2, B_FIXED, 4'd10, 32'h0,        4'h0, 32'hCAFEF00D, OKAY};
      vecs[7]  = '{1'b0, 32'h24,   3'd3, B_INCR,  4'd11, 32'h0,        4'h0, 32'h0,        SLVERR};
      vecs[8]  = '{1'b1, 32'h24,   3'd2, B_RSVD,  4'd12, 32'h0,        4'hF, 32'h0,        SLVERR};
      vecs[9]  = '{1'b0, 32'h24,   3'd2, B_RSVD,  4'd13, 32'h0,        4'h0, 32'h0,        SLVERR};
      vecs[10] = '{1'b0, 32'h24,   3'd1, B_INCR,  4'd14, 32'h0,        4'h0, 32'hCAFEF00D, OKAY};

      // Reset: readies must stay low even with valids pending.
      ar_valid = 1'b1;
      aw_valid = 1'b1;
      repeat (3) @(posedge aclk);
      #1;
      chk("rst_ar_ready", ar_ready, 0);
      chk("rst_aw_ready", aw_ready, 0);
      chk("rst_w_ready", w_ready, 0);
      chk("rst_r_valid", r_valid, 0);
      chk("rst_b_valid", b_valid, 0);
      chk("rst_b_id", b_id, 0);
      chk("rst_b_resp", b_resp, 0);
      chk("rst_r_id", r_id, 0);
      chk("rst_r_resp", r_resp, 0);
      chk("rst_r_last", r_last, 0);
      ar_valid = 1'b0;
      aw_valid = 1'b0;
      aresetn = 1'b1;
      @(posedge aclk); #1;

      // Arbitration: read wins first after reset, then write wins.
      ar_addr = 32'h10; ar_len = 0; ar_size = 3'd2; ar_burst = B_INCR; ar_id = 4'd1;
      aw_addr = 32'h10; aw_len = 0; aw_size = 3'd2; aw_burst = B_INCR; aw_id = 4'd3;
      ar_valid = 1'b1;
      aw_valid = 1'b1;
      #1;
      chk("arb1_ar_ready", ar_ready, 1);
      chk("arb1_aw_ready", aw_ready, 0);
      @(posedge aclk); #1;
      ar_valid = 1'b0;
      collect_r(1);
      chk("arb1_read_beats", rd_n, 1);
      ar_valid = 1'b1;
      #1;
      chk("arb2_aw_ready", aw_ready, 1);
      chk("arb2_ar_ready", ar_ready, 0);
      @(posedge aclk); #1;
      aw_valid = 1'b0;
      ar_valid = 1'b0;
      do_w(32'hDEADBEEF, 4'hF, 1'b1);
      chk("single_b_valid_w1", b_valid, 1);
      do_b();
      chk("single_b_resp", b_resp_got, OKAY);
      chk("single_b_id", b_id_got, 3);

      do_ar(32'h10, 8'd0, 3'd2, B_INCR, 4'd5);
      chk("single_r_valid_t1", r_valid, 1);
      collect_r(1);
      chk("single_r_beats", rd_n, 1);
      chk("single_r_data", rd_data[0], 32'hDEADBEEF);
      chk("single_r_last", rd_last[0], 1);
      chk("single_r_resp", rd_resp[0], OKAY);
      chk("single_r_id", rd_id[0], 5);
      #1;
      chk("single_ar_ready_after", ar_ready, 1);

      // Table of single-beat transactions.
      for (int i = 0; i < NV; i++) begin
         if (vecs[i].wr) begin
            wd[0] = vecs[i].data;
            ws[0] = vecs[i].strb;
            wr_burst(vecs[i].addr, 8'd0, vecs[i].size, vecs[i].burst, vecs[i].id, 0);
            chk($sformatf("vec%0d_bresp", i), b_resp_got, vecs[i].exp_resp);
            chk($sformatf("vec%0d_bid", i), b_id_got, vecs[i].id);
         end else begin
            do_ar(vecs[i].addr, 8'd0, vecs[i].size, vecs[i].burst, vecs[i].id);
            collect_r(1);
            chk($sformatf("vec%0d_beats", i), rd_n, 1);
            chk($sformatf("vec%0d_rdata", i), rd_data[0], vecs[i].exp_data);
            chk($sformatf("vec%0d_rresp", i), rd_resp[0], vecs[i].exp_resp);
            chk($sformatf("vec%0d_rid", i), rd_id[0], vecs[i].id);
            chk($sformatf("vec%0d_rlast", i), rd_last[0], 1);
         end
      end

      // INCR burst with a partial strobe on beat 2.
      for (int i = 0; i < 4; i++) begin wd[i] = 32'h0; ws[i] = 4'hF; end
      wr_burst(32'h100, 8'd3, 3'd2, B_INCR, 4'd0, 3);
      for (int i = 0; i < 4; i++) wd[i] = 32'(i + 1);
      ws[2] = 4'h3;
      wr_burst(32'h100, 8'd3, 3'd2, B_INCR, 4'd2, 3);
      chk("incr_b_resp", b_resp_got, OKAY);
      do_ar(32'h100, 8'd3, 3'd2, B_INCR, 4'd2);
      collect_r(4);
      chk("incr_beats", rd_n, 4);
      for (int i = 0; i < 4; i++) chk($sformatf("incr_data%0d", i), rd_data[i], 32'(i + 1));

      // Backpressure on an 8-beat read.
      for (int i = 0; i < 8; i++) begin wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; end
      wr_burst(32'h200, 8'd7, 3'd2, B_INCR, 4'd6, 7);
      do_ar(32'h200, 8'd7, 3'd2, B_INCR, 4'd6);
      k = 0; n = 0; stall = 0;
      while (k < 8 && n < 60) begin
         if (k == 3 && stall < 3) begin
            r_ready = 1'b0;
            #1;
            chk("bp_hold_valid", r_valid, 1);
            chk("bp_hold_data", r_data, 32'hA3);
            chk("bp_hold_last", r_last, 0);
            stall++;
         end else begin
            r_ready = 1'b1;
            #1;
            if (r_valid) begin
               chk($sformatf("bp_data%0d", k), r_data, 32'hA0 + 32'(k));
               chk($sformatf("bp_last%0d", k), r_last, (k == 7) ? 1 : 0);
               k++;
            end
         end
         @(posedge aclk); #1;
         n++;
      end
      r_ready = 1'b0;
      if (k != 8) timeout("bp_beats");

      // WRAP read at 0x38.
      for (int i = 0; i < 4; i++) begin wd[i] = 32'hB0 + 32'(i); ws[i] = 4'hF; end
      wr_burst(32'h30, 8'd3, 3'd2, B_INCR, 4'd1, 3);
      do_ar(32'h38, 8'd3, 3'd2, B_WRAP, 4'd9);
      collect_r(4);
      chk("wrap_beats", rd_n, 4);
      for (int i = 0; i < 4; i++) chk($sformatf("wrap_last%0d", i), rd_last[i], (i == 3) ? 1 : 0);
`ifdef AXI_SRAM_WRAP_BURST_EN
      chk("wrap_data0", rd_data[0], 32'hB2);
      chk("wrap_data1", rd_data[1], 32'hB3);
      chk("wrap_data2", rd_data[2], 32'hB0);
      chk("wrap_data3", rd_data[3], 32'hB1);
      for (int i = 0; i < 4; i++) chk($sformatf("wrap_resp%0d", i), rd_resp[i], OKAY);
`else
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("wrap_data%0d", i), rd_data[i], 32'h0);
         chk($sformatf("wrap_resp%0d", i), rd_resp[i], SLVERR);
      end
`endif

      // Early w_last: two beats land, response is SLVERR.
      for (int i = 0; i < 4; i++) begin wd[i] = 32'h0; ws[i] = 4'hF; end
      wr_burst(32'h300, 8'd3, 3'd2, B_INCR, 4'd0, 3);
      wd[0] = 32'h55; wd[1] = 32'h66;
      wr_burst(32'h300, 8'd3, 3'd2, B_INCR, 4'd4, 1);
      chk("badlast_b_resp", b_resp_got, SLVERR);
      chk("badlast_b_id", b_id_got, 4);
      do_ar(32'h300, 8'd3, 3'd2, B_INCR, 4'd4);
      collect_r(4);
      chk("badlast_beats", rd_n, 4);
      chk("badlast_data0", rd_data[0], 32'h55);
      chk("badlast_data1", rd_data[1], 32'h66);
      chk("badlast_data2", rd_data[2], 32'h0);
      chk("badlast_data3", rd_data[3], 32'h0);

      // Reset in the middle of a read burst.
      do_ar(32'h200, 8'd7, 3'd2, B_INCR, 4'd7);
      r_ready = 1'b1;
      @(posedge aclk); #1;
      @(posedge aclk); #1;
      aresetn = 1'b0;
      #1;
      chk("midrst_r_valid", r_valid, 0);
      chk("midrst_ar_ready", ar_ready, 0);
      chk("midrst_r_last", r_last, 0);
      r_ready = 1'b0;
      @(posedge aclk); #1;
      aresetn = 1'b1;
      @(posedge aclk); #1;
      do_ar(32'h204, 8'd0, 3'd2, B_INCR, 4'd8);
      collect_r(1);
      chk("midrst_fresh_beats", rd_n, 1);
      chk("midrst_fresh_data", rd_data[0], 32'hA1);
      chk("midrst_fresh_resp", rd_resp[0], OKAY);
      chk("midrst_fresh_id", rd_id[0], 8);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
